ask_keyer: RTL and testbench
============================

ASK_KEYER -- requirements
Module: ask_keyer

Interface
REQ-001 Parameter W, default 12, width of each carrier sample and each output sample (unsigned).
REQ-002 Parameter NCH, default 4, number of carrier channels keyed in parallel by one bit stream.
REQ-003 Parameter FRAME_W, default 8, number of bits per data frame.
REQ-004 Parameter DIV_W, default 16, width of the symbol-period divider.
REQ-005 clk  input  1  single clock domain for all logic.
REQ-006 rst_n  input  1  synchronous reset, active-low, sampled on rising clk.
REQ-007 wave_in  input  NCH*W  packed carriers; channel k occupies bits [k*W +: W].
REQ-008 data_in  input  FRAME_W  frame to transmit, MSB sent first.
REQ-009 data_valid  input  1  data_in is valid.
REQ-010 data_ready  output  1  block accepts data_in this cycle.
REQ-011 sym_div  input  DIV_W  clk cycles per symbol; a value of 0 is treated as 1.
REQ-012 mode  input  2  keying mode: 00 OOK, 01 ASK-half, 10 ASK-quarter, 11 bypass.
REQ-013 enable  input  1  transmission enable.
REQ-014 ask_out  output  NCH*W  packed keyed outputs, same channel packing as wave_in.
REQ-015 key  output  1  current symbol bit being applied.
REQ-016 busy  output  1  high while in SEND.
REQ-017 frame_done  output  1  one-cycle pulse on completion of the last symbol of a frame.

Function
REQ-018 The FSM SHALL have two states: IDLE and SEND.
REQ-019 In IDLE, data_ready SHALL equal enable, key SHALL be 0, and busy SHALL be 0.
REQ-020 A transfer SHALL occur on a cycle with data_valid=1 and data_ready=1.
- Transfer effects: load data_in into the shift register, latch max(sym_div,1) as the symbol period, clear the divider counter, set the bit counter to FRAME_W-1, enter SEND.
REQ-021 In SEND, key SHALL equal the shift-register MSB.
REQ-022 In SEND, the divider counter SHALL increment each cycle; the symbol ends when counter = period-1.
- At symbol end with bit counter > 0: shift left by one, decrement the bit counter, clear the divider.
REQ-023 At the end of the last symbol (bit counter = 0), frame_done SHALL pulse for one cycle.
REQ-024 data_ready SHALL be high in the last cycle of the last symbol when enable=1, to allow gapless back-to-back frames.
- If a transfer occurs in that cycle: reload and stay in SEND with no idle cycle.
- Otherwise: return to IDLE.
REQ-025 sym_div and mode changes during SEND SHALL NOT alter the latched period; mode SHALL take effect on the next cycle.
REQ-026 If enable deasserts during SEND, the block SHALL abort to IDLE on the next edge.
- Abort: no frame_done pulse; shift register and counters cleared.
REQ-027 Per channel, the keyed value SHALL be computed from wave_in channel k:
- key=1: the carrier value.
- key=0, OOK: 0.
- key=0, ASK-half: carrier >> 1.
- key=0, ASK-quarter: carrier >> 2.
- bypass: the carrier, regardless of key.
REQ-028 ask_out SHALL be registered: it reflects the key and wave_in of the previous cycle (latency 1 clk).
REQ-029 key and busy SHALL be registered state outputs, with no combinational path from data_valid to key.
REQ-030 data_ready SHALL depend combinationally only on state, counters, and enable; it SHALL NOT depend on data_valid.

Reset
REQ-031 While rst_n=0 at a rising edge, the block SHALL enter IDLE.
- Reset values: ask_out=0, key=0, busy=0, frame_done=0, shift register and counters=0.
REQ-032 Reset asserted mid-frame SHALL discard the frame, with no frame_done pulse.
REQ-033 data_ready SHALL be 0 during any cycle in which rst_n=0.

Structure
REQ-034 A shared package SHALL define the mode encoding enum (MODE_OOK, MODE_HALF, MODE_QUARTER, MODE_BYPASS) and the FSM state enum.
REQ-035 One sub-module, ask_level, SHALL implement the per-channel keying of REQ-027 for one W-bit sample.
- ask_level is instantiated NCH times via generate.
REQ-036 The top level SHALL contain the FSM, counters, shift register, and output registers.

Verification
REQ-037 Stimulus: frame 8'hA5, sym_div=4, OOK, constant carrier 12'h800.
- Response: key sequence 1,0,1,0,0,1,0,1, each held 4 cycles.
- ask_out alternates 12'h800/0, lagging key by 1 cycle.
- frame_done pulses once, 32 cycles after the transfer.
REQ-038 Stimulus: data_valid held with 8'hFF then 8'h00, sym_div=2.
- Response: second transfer in the final cycle of the first frame.
- busy stays high 32 consecutive cycles; key is 1 for 16 cycles, then 0 for 16 cycles.
REQ-039 Stimulus: ASK-half and ASK-quarter with carrier 12'hFFC, key=0.
- Response: ask_out = 12'h7FE and 12'h3FF respectively.
- Bypass mode passes 12'hFFC throughout.
REQ-040 Stimulus: sym_div=0.
- Response: one cycle per symbol; frame_done 8 cycles after the transfer.
REQ-041 Stimulus: enable dropped at bit 3, or rst_n=0 mid-frame.
- Response: IDLE next edge, key=0, no frame_done.
- After reset: ask_out=0, data_ready=0 while reset is held.
REQ-042 Stimulus: NCH=4 with distinct carriers 12'h100, 12'h200, 12'h300, 12'h400, key=1.
- Response: each ask_out channel matches its own wave_in channel; no cross-channel mixing.

Source files
------------

// File: rtl/ask_keyer_pkg.sv
// ask_keyer_pkg: shared keying-mode and FSM state encodings
package ask_keyer_pkg;
  typedef enum logic [1:0] {
    MODE_OOK     = 2'b00,
    MODE_HALF    = 2'b01,
    MODE_QUARTER = 2'b10,
    MODE_BYPASS  = 2'b11
  } mode_e;
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;
endpackage

// File: rtl/ask_level.sv
// ask_level: keys one carrier sample according to the current bit and mode
module ask_level
  import ask_keyer_pkg::*;
#(
  parameter int W = 12
) (
  input  logic [W-1:0] carrier,
  input  logic         key,
  input  logic [1:0]   mode,
  output logic [W-1:0] level
);
  // full carrier on a mark or in bypass, otherwise attenuated per mode
  always_comb
    level = (key || mode == MODE_BYPASS) ? carrier :
            (mode == MODE_HALF)          ? carrier >> 1 :
            (mode == MODE_QUARTER)       ? carrier >> 2 : '0;
endmodule

// File: rtl/ask_keyer.sv
// ask_keyer: serialises frames MSB-first and amplitude-keys NCH carriers
module ask_keyer
  import ask_keyer_pkg::*;
#(
  parameter int W       = 12,
  parameter int NCH     = 4,
  parameter int FRAME_W = 8,
  parameter int DIV_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH*W-1:0]   wave_in,
  input  logic [FRAME_W-1:0] data_in,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic [DIV_W-1:0]   sym_div,
  input  logic [1:0]         mode,
  input  logic               enable,
  output logic [NCH*W-1:0]   ask_out,
  output logic               key,
  output logic               busy,
  output logic               frame_done
);
  localparam int BW = FRAME_W > 1 ? $clog2(FRAME_W) : 1;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d, per_q, per_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic               done_q, done_d;
  logic [NCH*W-1:0]   out_q, out_d;
  logic               sym_end, last, xfer;

  // key is the shift-register MSB; the register is zero outside SEND
  assign key        = sh_q[FRAME_W-1];
  assign busy       = state_q == SEND;
  assign frame_done = done_q;
  assign ask_out    = out_q;

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_ch
      ask_level #(.W(W)) u_lvl (
        .carrier(wave_in[k*W +: W]),
        .key    (key),
        .mode   (mode),
        .level  (out_d[k*W +: W])
      );
    end
  endgenerate

  // next-state: abort beats everything, a transfer may overlap the final symbol cycle
  always_comb begin
    sym_end    = cnt_q == per_q - DIV_W'(1);
    last       = state_q == SEND && sym_end && bit_q == '0;
    data_ready = rst_n && enable && (state_q == IDLE || last);
    xfer       = data_valid && data_ready;
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    bit_d      = bit_q;
    done_d     = 1'b0;
    if (state_q == SEND && !enable) begin
      state_d = IDLE;
      sh_d    = '0;
      cnt_d   = '0;
      per_d   = '0;
      bit_d   = '0;
    end else if (xfer) begin
      state_d = SEND;
      sh_d    = data_in;
      per_d   = sym_div == '0 ? DIV_W'(1) : sym_div;
      cnt_d   = '0;
      bit_d   = BW'(FRAME_W - 1);
      done_d  = last;
    end else if (last) begin
      state_d = IDLE;
      sh_d    = '0;
      cnt_d   = '0;
      done_d  = 1'b1;
    end else if (state_q == SEND) begin
      sh_d  = sym_end ? sh_q << 1 : sh_q;
      bit_d = sym_end ? bit_q - BW'(1) : bit_q;
      cnt_d = sym_end ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // state, counters and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end
endmodule

// File: tb/tb_ask_keyer.sv
// tb_ask_keyer: directed table and sequence checks for ask_keyer
module tb_ask_keyer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] wave_in;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic [15:0] sym_div;
  logic [1:0]  mode;
  logic        enable;
  logic [47:0] ask_out;
  logic        key;
  logic        busy;
  logic        frame_done;
  int          errs = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  ask_keyer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wave_in   (wave_in),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .sym_div   (sym_div),
    .mode      (mode),
    .enable    (enable),
    .ask_out   (ask_out),
    .key       (key),
    .busy      (busy),
    .frame_done(frame_done)
  );

  typedef struct {
    logic        kone;
    logic [1:0]  mode;
    logic [47:0] wave;
    logic [47:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [15:0] div);
    data_in    = d;
    sym_div    = div;
    data_valid = 1'b1;
    enable     = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  vec_t vt[11];

  initial begin
    int fd;
    logic [47:0] c800;
    logic [7:0]  fr;
    c800 = {4{12'h800}};
    vt[0]  = '{1'b0, 2'b00, {4{12'hFFC}}, 48'h0};
    vt[1]  = '{1'b0, 2'b01, {4{12'hFFC}}, {4{12'h7FE}}};
    vt[2]  = '{1'b0, 2'b10, {4{12'hFFC}}, {4{12'h3FF}}};
    vt[3]  = '{1'b0, 2'b11, {4{12'hFFC}}, {4{12'hFFC}}};
    vt[4]  = '{1'b0, 2'b10, {12'h400, 12'h300, 12'h200, 12'h100}, {12'h100, 12'h0C0, 12'h080, 12'h040}};
    vt[5]  = '{1'b0, 2'b01, {12'h400, 12'h300, 12'h200, 12'h100}, {12'h200, 12'h180, 12'h100, 12'h080}};
    vt[6]  = '{1'b1, 2'b00, {4{12'hFFC}}, {4{12'hFFC}}};
    vt[7]  = '{1'b1, 2'b00, {12'h400, 12'h300, 12'h200, 12'h100}, {12'h400, 12'h300, 12'h200, 12'h100}};
    vt[8]  = '{1'b1, 2'b01, {4{12'hFFC}}, {4{12'hFFC}}};
    vt[9]  = '{1'b1, 2'b10, {12'h400, 12'h300, 12'h200, 12'h100}, {12'h400, 12'h300, 12'h200, 12'h100}};
    vt[10] = '{1'b1, 2'b11, {4{12'h123}}, {4{12'h123}}};
    rst_n = 1'b0; wave_in = c800; data_in = '0; data_valid = 1'b0;
    sym_div = 16'd4; mode = 2'b00; enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ask_out", ask_out, 0);
    chk("rst_key", key, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_data_ready", data_ready, 0);
    rst_n = 1'b1; enable = 1'b0;
    @(negedge clk);
    chk("idle_ready_disabled", data_ready, 0);
    enable = 1'b1;
    #1 chk("idle_ready_enabled", data_ready, 1);
    enable = 1'b0;
    // keying table: key=0 rows in IDLE, key=1 rows inside a long all-ones frame
    for (int i = 0; i < 11; i++) begin
      if (vt[i].kone && !busy) send(8'hFF, 16'd1000);
      mode = vt[i].mode; wave_in = vt[i].wave;
      @(negedge clk);
      chk($sformatf("table_%0d", i), ask_out, vt[i].exp);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("table_abort_busy", busy, 0);
    // A5 frame, 4 cycles per symbol, OOK
    mode = 2'b00; wave_in = c800;
    send(8'hA5, 16'd4);
    fr = 8'hA5;
    for (int c = 0; c < 32; c++) begin
      chk($sformatf("a5_key_%0d", c), key, fr[7 - c/4]);
      chk($sformatf("a5_out_%0d", c), ask_out, c == 0 ? 48'h0 : (fr[7 - (c-1)/4] ? c800 : 48'h0));
      chk($sformatf("a5_fd_%0d", c), {busy, frame_done}, 2'b10);
      @(negedge clk);
    end
    chk("a5_done", {busy, frame_done, key}, 3'b010);
    @(negedge clk);
    chk("a5_done_once", frame_done, 0);
    // back-to-back FF then 00, sym_div=2
    data_in = 8'hFF; sym_div = 16'd2; data_valid = 1'b1; enable = 1'b1;
    @(negedge clk);
    data_in = 8'h00;
    for (int c = 0; c < 32; c++) begin
      chk($sformatf("b2b_busy_%0d", c), busy, 1);
      chk($sformatf("b2b_key_%0d", c), key, c < 16);
      if (c == 15) chk("b2b_ready_last", data_ready, 1);
      if (c == 3) chk("b2b_ready_mid", data_ready, 0);
      chk($sformatf("b2b_fd_%0d", c), frame_done, c == 16);
      if (c == 16) data_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_end", {busy, frame_done}, 2'b01);
    @(negedge clk);
    // sym_div=0 acts as one cycle per symbol
    send(8'h5A, 16'd0);
    fr = 8'h5A;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("div0_key_%0d", c), {busy, frame_done, key}, {2'b10, fr[7 - c]});
      @(negedge clk);
    end
    chk("div0_done", {busy, frame_done}, 2'b01);
    @(negedge clk);
    // enable dropped mid-frame
    send(8'hA5, 16'd4);
    repeat (13) @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_state", {busy, key}, 2'b00);
    fd = 0;
    repeat (40) begin @(negedge clk); fd += frame_done; end
    chk("abort_no_done", fd, 0);
    // reset mid-frame
    send(8'hFF, 16'd4);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_mid_ready", data_ready, 0);
    @(negedge clk);
    chk("rst_mid_state", {busy, key, frame_done}, 3'b000);
    chk("rst_mid_out", ask_out, 0);
    chk("rst_mid_ready_hold", data_ready, 0);
    rst_n = 1'b1;
    fd = 0;
    repeat (40) begin @(negedge clk); fd += frame_done; end
    chk("rst_mid_no_done", fd + busy, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
